// File: rtl/aes128_type_pkg.sv
// Shared AES-128 types, constants and byte-level helpers for the cipher engines.
package aes128_type_pkg;

  localparam int AES_ROUNDS = 10;

  // Key-step direction select.
  localparam logic KEY_DIR_FWD = 1'b0;
  localparam logic KEY_DIR_REV = 1'b1;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry x sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant lookup; indices outside 1..10 yield zero.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    if (idx >= 4'd1 && idx <= 4'd10) r = RCON[idx];
    return r;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    KEY_FWD,
    ADD_KEY0,
    INV_SHIFT_ROWS,
    INV_SUB_BYTES,
    ADD_ROUND_KEY,
    INV_MIX_COLUMNS,
    STORE
  } dec_state_t;

endpackage

// File: rtl/aes128_key_step.sv
// One AES-128 key-schedule step, forward (K(r) -> K(r+1)) or reverse (K(r) -> K(r-1)).
module aes128_key_step
  import aes128_type_pkg::*;
(
  input  logic [127:0] rkey,
  input  logic [3:0]   round,
  input  logic         dir_i,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sel_word, rot_word, sub_word, head_word;
  logic [3:0]  rcon_idx;

  assign w0 = rkey[127:96];
  assign w1 = rkey[95:64];
  assign w2 = rkey[63:32];
  assign w3 = rkey[31:0];

  // Reverse steps rebuild the new w3 (w3^w2) first and feed that to SubWord.
  assign sel_word = (dir_i == KEY_DIR_REV) ? (w3 ^ w2) : w3;
  assign rot_word = {sel_word[23:0], sel_word[31:24]};
  // Forward uses Rcon of the round being produced, reverse of the round being undone.
  assign rcon_idx = (dir_i == KEY_DIR_REV) ? round : (round + 4'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
    end
  endgenerate

  assign head_word = w0 ^ sub_word ^ {rcon_of(rcon_idx), 24'h000000};

  // Assemble the next key words for the selected direction.
  always_comb begin
    next_key = rkey;
    if (dir_i == KEY_DIR_REV) begin
      next_key = {head_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end else begin
      next_key[127:96] = head_word;
      next_key[95:64]  = w1 ^ head_word;
      next_key[63:32]  = w2 ^ w1 ^ head_word;
      next_key[31:0]   = w3 ^ w2 ^ w1 ^ head_word;
    end
  end

endmodule

// File: rtl/aes128_decrypt_fsm.sv
// Iterative AES-128 inverse cipher: byte-serial InvSubBytes, column-serial InvMixColumns.
module aes128_decrypt_fsm
  import aes128_type_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic [127:0] result_o,
  output logic         valid_o,
  output logic         ready_o
);

  localparam logic [3:0] LAST_FWD = 4'(AES_ROUNDS - 1);

  dec_state_t   state_reg, state_next;
  logic [127:0] data_reg, data_next;
  logic [127:0] rkey_reg, rkey_next;
  logic [3:0]   round_reg, round_next;
  logic [3:0]   byte_idx_reg, byte_idx_next;
  logic [1:0]   col_idx_reg, col_idx_next;
  logic [127:0] result_reg, result_next;
  logic         valid_reg, valid_next;

  logic [127:0] isr_data;
  logic [127:0] step_key;
  logic         key_dir;
  logic [6:0]   byte_lsb;
  logic [6:0]   col_lsb;
  logic [31:0]  col_word;
  logic [31:0]  mixed_col;
  logic [7:0]   col_bytes [4];

  // GF(2^8) constant multipliers for the InvMixColumns matrix.
  function automatic logic [7:0] mul_9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction
  function automatic logic [7:0] mul_b(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction
  function automatic logic [7:0] mul_d(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction
  function automatic logic [7:0] mul_e(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // The same key-step block serves both schedule directions.
  assign key_dir = (state_reg == ADD_ROUND_KEY) ? KEY_DIR_REV : KEY_DIR_FWD;

  aes128_key_step u_key_step (
    .rkey     (rkey_reg),
    .round    (round_reg),
    .dir_i    (key_dir),
    .next_key (step_key)
  );

  genvar gi;
  generate
    // InvShiftRows: byte at (row, col) comes from (row, col - row mod 4).
    for (gi = 0; gi < 16; gi++) begin : g_isr
      localparam int ROW     = gi % 4;
      localparam int COL     = gi / 4;
      localparam int SRC_COL = (COL - ROW + 4) % 4;
      localparam int SRC     = 4 * SRC_COL + ROW;
      assign isr_data[127-8*gi -: 8] = data_reg[127-8*SRC -: 8];
    end
    // One InvMixColumns column: row r = 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3].
    for (gi = 0; gi < 4; gi++) begin : g_imc
      assign col_bytes[gi] = col_word[31-8*gi -: 8];
      assign mixed_col[31-8*gi -: 8] = mul_e(col_bytes[gi])
                                     ^ mul_b(col_bytes[(gi+1)%4])
                                     ^ mul_d(col_bytes[(gi+2)%4])
                                     ^ mul_9(col_bytes[(gi+3)%4]);
    end
  endgenerate

  // Byte i lives at offset 8*(15-i); column c at offset 32*(3-c).
  assign byte_lsb = {~byte_idx_reg, 3'b000};
  assign col_lsb  = {~col_idx_reg, 5'b00000};
  assign col_word = data_reg[col_lsb +: 32];

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_next    = state_reg;
    data_next     = data_reg;
    rkey_next     = rkey_reg;
    round_next    = round_reg;
    byte_idx_next = byte_idx_reg;
    col_idx_next  = col_idx_reg;
    result_next   = result_reg;
    valid_next    = valid_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          data_next     = data_i;
          rkey_next     = key_i;
          round_next    = 4'd0;
          byte_idx_next = 4'd0;
          col_idx_next  = 2'd0;
          valid_next    = 1'b0;
          state_next    = KEY_FWD;
        end
      end
      KEY_FWD: begin
        rkey_next  = step_key;
        round_next = round_reg + 4'd1;
        if (round_reg == LAST_FWD) state_next = ADD_KEY0;
      end
      ADD_KEY0: begin
        data_next  = data_reg ^ rkey_reg;
        state_next = INV_SHIFT_ROWS;
      end
      INV_SHIFT_ROWS: begin
        data_next  = isr_data;
        state_next = INV_SUB_BYTES;
      end
      INV_SUB_BYTES: begin
        data_next[byte_lsb +: 8] = inv_sbox(data_reg[byte_lsb +: 8]);
        byte_idx_next = byte_idx_reg + 4'd1;
        if (byte_idx_reg == 4'd15) state_next = ADD_ROUND_KEY;
      end
      ADD_ROUND_KEY: begin
        // Step the key back first so the XOR uses K(round-1).
        rkey_next  = step_key;
        round_next = round_reg - 4'd1;
        data_next  = data_reg ^ step_key;
        state_next = (round_reg == 4'd1) ? STORE : INV_MIX_COLUMNS;
      end
      INV_MIX_COLUMNS: begin
        data_next[col_lsb +: 32] = mixed_col;
        col_idx_next = col_idx_reg + 2'd1;
        if (col_idx_reg == 2'd3) state_next = INV_SHIFT_ROWS;
      end
      STORE: begin
        result_next = data_reg;
        valid_next  = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      rkey_reg     <= '0;
      round_reg    <= '0;
      byte_idx_reg <= '0;
      col_idx_reg  <= '0;
      result_reg   <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      rkey_reg     <= rkey_next;
      round_reg    <= round_next;
      byte_idx_reg <= byte_idx_next;
      col_idx_reg  <= col_idx_next;
      result_reg   <= result_next;
      valid_reg    <= valid_next;
    end
  end

  assign result_o = result_reg;
  assign valid_o  = valid_reg;
  assign ready_o  = (state_reg == IDLE);

endmodule
